// File: rtl/mips_if_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_if_pkg;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HOLD
    } fetch_state_t;

    // All-zero word decodes as sll $0,$0,0, the canonical MIPS no-op.
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    // Byte distance between consecutive instruction words.
    localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched {incremented_pc, instruction}
// pair that arrives while the IF/ID register is stalled and still occupied.
module if_skid_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [63:0] load_word,
    output logic        held_valid,
    output logic [63:0] held_word
);

    // Occupancy flag: clear wins so a redirect can never leave a stale entry.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every register samples pre-edge values.
        if (reset || clear) begin
            held_valid <= 1'b0;
        end else if (load) begin
            held_valid <= 1'b1;
        end
    end

    // Payload capture; only meaningful while held_valid is set.
    always_ff @(posedge clk) begin
        // NOTE: payload is deliberately not reset; held_valid alone qualifies it.
        if (load) begin
            held_word <= load_word;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: owns the PC, issues one word read at a time over a
// req/ready + rvalid handshake and fills the IF/ID register, honouring
// ID-stage stall and branch/jump redirect.
module if_fetch_unit
    import mips_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        IF_valid,
    output logic [31:0] IF_incrementedPC,
    output logic [31:0] IF_instruction
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  fetch_pc;
    logic         rd_accept;
    logic         slot_free;
    logic         skid_load;
    logic         skid_clear;
    logic         skid_valid;
    logic [63:0]  skid_word;

    // Request is a pure decode of registered state: no input reaches it.
    assign o_imem_req  = (state == S_REQ);
    assign o_imem_addr = pc;
    assign rd_accept   = o_imem_req && i_imem_ready;

    // The IF/ID slot can take a new word if it is empty or being consumed.
    assign slot_free   = !IF_valid || !i_stall;
    assign skid_load   = (state == S_WAIT) && i_imem_rvalid && !slot_free && !i_redirect;
    assign skid_clear  = i_redirect || ((state == S_HOLD) && !i_stall);

    if_skid_buf u_skid (
        .clk        (i_clk),
        .reset      (i_reset),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_word  ({fetch_pc + PC_INC, i_imem_rdata}),
        .held_valid (skid_valid),
        .held_word  (skid_word)
    );

    // Fetch sequencer, PC and IF/ID output register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state            <= S_IDLE;
            pc               <= RESET_PC;
            fetch_pc         <= RESET_PC;
            IF_valid         <= 1'b0;
            IF_instruction   <= MIPS_NOP;
            IF_incrementedPC <= '0;
        end else if (i_redirect) begin
            // Redirect flushes the slot; IF_incrementedPC keeps its last value.
            pc             <= i_redirect_pc;
            IF_valid       <= 1'b0;
            IF_instruction <= MIPS_NOP;
            case (state)
                // A read still in flight must be swallowed before refetching.
                S_WAIT:  state <= i_imem_rvalid ? S_REQ : S_DRAIN;
                S_REQ:   state <= i_imem_ready  ? S_DRAIN : S_REQ;
                S_DRAIN: state <= i_imem_rvalid ? S_REQ : S_DRAIN;
                default: state <= S_REQ;
            endcase
        end else begin
            // Default consumption; a word loaded below overrides it.
            if (IF_valid && !i_stall) begin
                IF_valid       <= 1'b0;
                IF_instruction <= MIPS_NOP;
            end
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (rd_accept) begin
                        fetch_pc <= pc;
                        pc       <= pc + PC_INC;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (slot_free) begin
                            IF_valid         <= 1'b1;
                            IF_instruction   <= i_imem_rdata;
                            IF_incrementedPC <= fetch_pc + PC_INC;
                            state            <= S_REQ;
                        end else begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!i_stall) begin
                        {IF_incrementedPC, IF_instruction} <= skid_word;
                        IF_valid <= skid_valid;
                        state    <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (i_imem_rvalid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a transaction-level model of the
// fetch stream (expected PC, in-flight read, queue of live words) checked
// every cycle, plus directed scenarios with literal expectations.
module tb_if_fetch_unit;

    localparam logic [31:0] M_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] W_RESET_PC = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid;
    logic [31:0] if_inc, if_instr;

    // Second instance exercising the PC wrap from the top of the address space.
    logic        w_reset, w_stall, w_redirect, w_req, w_ready, w_rvalid, w_valid;
    logic [31:0] w_redirect_pc, w_addr, w_rdata, w_inc, w_instr;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_unit #(.RESET_PC(M_RESET_PC)) dut (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_redirect(redirect),
        .i_redirect_pc(redirect_pc), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_ready(imem_ready), .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
        .IF_valid(if_valid), .IF_incrementedPC(if_inc), .IF_instruction(if_instr)
    );

    if_fetch_unit #(.RESET_PC(W_RESET_PC)) dut_w (
        .i_clk(clk), .i_reset(w_reset), .i_stall(w_stall), .i_redirect(w_redirect),
        .i_redirect_pc(w_redirect_pc), .o_imem_req(w_req), .o_imem_addr(w_addr),
        .i_imem_ready(w_ready), .i_imem_rvalid(w_rvalid), .i_imem_rdata(w_rdata),
        .IF_valid(w_valid), .IF_incrementedPC(w_inc), .IF_instruction(w_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: distinct, non-zero word for every address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out, got no event, expected one (t=%0t)", name, $time);
    endtask

    // ---------------- memory responder (main DUT) ----------------
    int          mem_lat = 1;
    bit          mem_ready_cfg = 1'b1;
    bit          rsp_pend = 1'b0;
    bit          rsp_rst_edge = 1'b0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_addr = '0;

    initial begin
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            rsp_rst_edge = rst;
            @(negedge clk);
            if (rsp_rst_edge) rsp_pend = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (rsp_pend) begin
                if (rsp_cnt <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(rsp_addr);
                    rsp_pend    = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end
            imem_ready = mem_ready_cfg;
            if (!rsp_pend && imem_req === 1'b1 && imem_ready) begin
                rsp_pend = 1'b1;
                rsp_cnt  = mem_lat;
                rsp_addr = imem_addr;
            end
        end
    end

    // ---------------- memory responder (wrap DUT, always ready, 1 cycle) ----
    bit          w_pend = 1'b0;
    logic [31:0] w_paddr = '0;

    initial begin
        w_rvalid = 1'b0;
        w_rdata  = '0;
        forever begin
            @(negedge clk);
            w_rvalid = w_pend;
            w_rdata  = w_pend ? mem_word(w_paddr) : 32'h0;
            w_pend   = (w_req === 1'b1);
            w_paddr  = w_addr;
        end
    end

    // ---------------- transaction-level model + per-cycle compare ----------
    typedef struct {
        logic [31:0] inc;
        logic [31:0] instr;
    } out_t;

    out_t        live_q[$];
    out_t        new_out;
    bit          m_live = 1'b0;
    bit          m_inflight = 1'b0;
    bit          m_killed = 1'b0;
    bit          m_req = 1'b0;
    bit          m_accept;
    logic [31:0] m_pc = '0;
    logic [31:0] m_inf_addr = '0;
    logic [31:0] m_last_inc = '0;
    logic        s_rst, s_redir, s_stall, s_ready, s_rvalid;
    logic [31:0] s_rpc;

    initial begin
        forever begin
            @(posedge clk);
            s_rst = rst; s_redir = redirect; s_rpc = redirect_pc;
            s_stall = stall; s_ready = imem_ready; s_rvalid = imem_rvalid;
            #1;
            if (s_rst === 1'b1) begin
                m_live = 1'b1; m_pc = M_RESET_PC; live_q.delete();
                m_last_inc = '0; m_inflight = 1'b0; m_killed = 1'b0;
            end else if (m_live) begin
                m_accept = m_req && s_ready;
                // The word on display is taken by ID when not stalled.
                if (live_q.size() > 0 && !s_stall) void'(live_q.pop_front());
                if (s_rvalid && m_inflight) begin
                    m_inflight = 1'b0;
                    if (!m_killed && !s_redir) begin
                        new_out.inc   = m_inf_addr + 32'd4;
                        new_out.instr = mem_word(m_inf_addr);
                        live_q.push_back(new_out);
                    end
                end
                if (m_accept) begin
                    m_inflight = 1'b1; m_killed = 1'b0;
                    m_inf_addr = m_pc; m_pc = m_pc + 32'd4;
                end
                if (s_redir) begin
                    m_pc = s_rpc; live_q.delete();
                    if (m_inflight) m_killed = 1'b1;
                end
                if (live_q.size() > 0) m_last_inc = live_q[0].inc;
            end
            if (m_live) begin
                // A read is issued whenever none is in flight and a slot is free.
                m_req = !s_rst && !m_inflight && (live_q.size() < 2);
                check("m_req",   {31'b0, imem_req}, {31'b0, m_req});
                check("m_addr",  imem_addr, m_pc);
                check("m_valid", {31'b0, if_valid}, {31'b0, live_q.size() > 0});
                check("m_instr", if_instr, (live_q.size() > 0) ? live_q[0].instr : 32'h0);
                check("m_inc",   if_inc, (live_q.size() > 0) ? live_q[0].inc : m_last_inc);
            end
        end
    end

    // ---------------- directed scenarios ----------------
    int          nreq, nval, wc;
    logic [31:0] ra[3], va_inc[3], va_ins[3];
    int          vc[3];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; redirect = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int c = 0;
        while (if_valid !== 1'b1 && c < 40) begin @(negedge clk); c++; end
        if (if_valid !== 1'b1) timeout_fail(name);
    endtask

    task automatic wait_req(input string name);
        int c = 0;
        while (imem_req !== 1'b1 && c < 40) begin @(negedge clk); c++; end
        if (imem_req !== 1'b1) timeout_fail(name);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        w_reset = 1'b1; w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;
        w_ready = 1'b1;
        repeat (2) @(negedge clk);

        // 1) Reset values, then back-to-back fetch with 1-cycle memory.
        do_reset();
        check("rst_valid", {31'b0, if_valid}, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_inc",   if_inc,   32'h0);
        check("rst_req",   {31'b0, imem_req}, 32'h0);
        check("rst_addr",  imem_addr, 32'h0);
        nreq = 0; nval = 0;
        for (int c = 0; c < 20 && nval < 3; c++) begin
            @(negedge clk);
            if (imem_req === 1'b1 && nreq < 3) begin ra[nreq] = imem_addr; nreq++; end
            if (if_valid === 1'b1) begin
                va_inc[nval] = if_inc; va_ins[nval] = if_instr; vc[nval] = c; nval++;
            end
        end
        if (nval < 3 || nreq < 3) timeout_fail("s1_stream");
        else begin
            check("s1_req0", ra[0], 32'h0);
            check("s1_req1", ra[1], 32'h4);
            check("s1_req2", ra[2], 32'h8);
            check("s1_inc0", va_inc[0], 32'h4);
            check("s1_inc1", va_inc[1], 32'h8);
            check("s1_inc2", va_inc[2], 32'hC);
            check("s1_ins0", va_ins[0], 32'hFFFF_0000);
            check("s1_ins1", va_ins[1], 32'hFFFB_0004);
            check("s1_ins2", va_ins[2], 32'hFFF7_0008);
            check("s1_gap1", vc[1] - vc[0], 32'd2);
            check("s1_gap2", vc[2] - vc[1], 32'd2);
        end

        // 2) Stall three cycles while the next response arrives.
        do_reset();
        wait_valid("s2_first");
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("s2_hold_valid", {31'b0, if_valid}, 32'h1);
            check("s2_hold_inc",   if_inc,   32'h4);
            check("s2_hold_instr", if_instr, 32'hFFFF_0000);
            if (k > 0) check("s2_no_req", {31'b0, imem_req}, 32'h0);
        end
        stall = 1'b0;
        @(negedge clk);
        check("s2_skid_valid", {31'b0, if_valid}, 32'h1);
        check("s2_skid_inc",   if_inc,   32'h8);
        check("s2_skid_instr", if_instr, 32'hFFFB_0004);

        // 3) Redirect while waiting on a slow (3-cycle) read.
        mem_lat = 3;
        do_reset();
        wait_req("s3_req");
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0400;
        @(negedge clk);
        redirect = 1'b0;
        check("s3_valid", {31'b0, if_valid}, 32'h0);
        check("s3_req",   {31'b0, imem_req}, 32'h0);
        check("s3_pc",    imem_addr, 32'h0000_0400);
        wait_req("s3_req2");
        check("s3_addr", imem_addr, 32'h0000_0400);
        wait_valid("s3_out");
        check("s3_inc",   if_inc,   32'h0000_0404);
        check("s3_instr", if_instr, 32'hFBFF_0400);

        // 4) Redirect in the same cycle the read at 0x10 is accepted.
        mem_lat = 1;
        do_reset();
        wc = 0;
        while (!(imem_req === 1'b1 && imem_addr === 32'h10) && wc < 40) begin
            @(negedge clk); wc++;
        end
        if (!(imem_req === 1'b1 && imem_addr === 32'h10)) timeout_fail("s4_req10");
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        redirect = 1'b0;
        check("s4_drain_req", {31'b0, imem_req}, 32'h0);
        check("s4_valid",     {31'b0, if_valid}, 32'h0);
        wait_req("s4_req2");
        check("s4_addr", imem_addr, 32'h0000_0200);
        wait_valid("s4_out");
        check("s4_inc",   if_inc,   32'h0000_0204);
        check("s4_instr", if_instr, 32'hFDFF_0200);

        // 5) Reset while a read is outstanding.
        mem_lat = 3;
        do_reset();
        wait_valid("s5_first");
        stall = 1'b1;
        wait_req("s5_req");
        @(negedge clk);
        check("s5_pre_valid", {31'b0, if_valid}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        check("s5_valid", {31'b0, if_valid}, 32'h0);
        check("s5_instr", if_instr, 32'h0);
        check("s5_inc",   if_inc,   32'h0);
        check("s5_req",   {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        check("s5_restart_req",  {31'b0, imem_req}, 32'h1);
        check("s5_restart_addr", imem_addr, 32'h0);
        wait_valid("s5_out");
        check("s5_out_inc", if_inc, 32'h4);

        // 6) Mixed soak: random stall, redirect, ready and latency.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            stall         = ($urandom_range(0, 3) == 0);
            redirect      = ($urandom_range(0, 15) == 0);
            redirect_pc   = $urandom_range(0, 255) << 2;
            mem_ready_cfg = ($urandom_range(0, 2) != 0);
            mem_lat       = $urandom_range(1, 3);
        end
        @(negedge clk);
        stall = 1'b0; redirect = 1'b0; mem_ready_cfg = 1'b1;
        repeat (8) @(negedge clk);

        // 7) PC wrap from RESET_PC = 0xFFFF_FFFC on the second instance.
        w_reset = 1'b0;
        nreq = 0; nval = 0;
        for (int c = 0; c < 20 && (nreq < 2 || nval < 1); c++) begin
            @(negedge clk);
            if (w_req === 1'b1 && nreq < 2) begin ra[nreq] = w_addr; nreq++; end
            if (w_valid === 1'b1 && nval < 1) begin
                va_inc[0] = w_inc; va_ins[0] = w_instr; nval++;
            end
        end
        if (nreq < 2 || nval < 1) timeout_fail("s7_wrap");
        else begin
            check("s7_req0",  ra[0], 32'hFFFF_FFFC);
            check("s7_inc",   va_inc[0], 32'h0000_0000);
            check("s7_instr", va_ins[0], 32'h0003_FFFC);
            check("s7_req1",  ra[1], 32'h0000_0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the MIPS pipeline.
- Owns the PC and issues word reads to instruction memory over a req/ready + rvalid handshake.
- Writes fetched instructions plus PC+4 to the IF/ID pipeline register.
- Honours ID-stage stall and branch/jump redirect; never holds more than one memory read outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned).

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous active-high reset
i_stall  in  1  IF/ID load inhibit from hazard unit; output held while 1
i_redirect  in  1  branch/jump taken; load i_redirect_pc
i_redirect_pc  in  32  redirect target
o_imem_req  out  1  read request
o_imem_addr  out  32  read address (= PC)
i_imem_ready  in  1  request accepted this cycle when req&ready
i_imem_rvalid  in  1  read data valid (>=1 cycle after accept)
i_imem_rdata  in  32  instruction word
IF_valid  out  1  IF_instruction/IF_incrementedPC hold a live instruction
IF_incrementedPC  out  32  fetch address + 4
IF_instruction  out  32  fetched word; 32'h0 (NOP) when IF_valid=0

Behaviour:
- Reset (i_reset=1 at edge) sets:
  - PC=RESET_PC, state=S_IDLE, kill flag=0, skid empty.
  - IF_valid=0, IF_instruction=0, IF_incrementedPC=0.
  - o_imem_req=0; o_imem_addr=RESET_PC from the following cycle.
  - Reset mid-transaction abandons any outstanding read; its rvalid is ignored only if it arrives while i_reset=1. After reset the memory is required to have no read in flight.
- States: S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_HOLD.
  - S_IDLE: one cycle, then S_REQ.
  - S_REQ: o_imem_req=1, o_imem_addr=PC. On req&ready: fetch_pc<=PC, PC<=PC+4 (mod 2^32), go S_WAIT.
  - S_WAIT: on rvalid, load the word with IF_incrementedPC<=PC.
    - If the output slot is free (IF_valid=0 or i_stall=0): load the output register, IF_valid<=1, go S_REQ.
    - Else: load the skid buffer, go S_HOLD.
  - S_HOLD: o_imem_req=0. When i_stall=0, output<=skid, skid cleared, go S_REQ.
  - S_DRAIN: discard the next rvalid (no output change), then go S_REQ.
- Consumption: the output is consumed at any edge with IF_valid=1 and i_stall=0. If no new word loads that edge, IF_valid<=0 and IF_instruction<=0; IF_incrementedPC holds.
- Stall: while i_stall=1 and IF_valid=1, IF_valid, IF_instruction and IF_incrementedPC are held bit-exact.
- Redirect has priority over all except reset:
  - PC<=i_redirect_pc, IF_valid<=0, IF_instruction<=0, skid cleared.
  - Next state:
    - From S_WAIT without rvalid that cycle: S_DRAIN.
    - From S_WAIT with rvalid that cycle: data dropped, S_REQ.
    - From S_REQ with req&ready the same cycle: the accepted old-address read is killed, S_DRAIN.
    - From S_REQ without acceptance, or from S_HOLD/S_IDLE: S_REQ.
  - Redirect during S_DRAIN stays in S_DRAIN; redirect with rvalid in S_DRAIN goes to S_REQ.
- Redirect overrides stall in the same cycle.
- o_imem_req is a decode of registered state only, with no combinational path from any input.
- Throughput: one instruction per 2 cycles with single-cycle memory (accept, then rvalid).
- Misaligned i_redirect_pc is passed through unchanged; it is not checked here.

Decomposition:
- Package mips_if_pkg holds:
  - state enum (S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_HOLD);
  - MIPS_NOP = 32'h0000_0000;
  - PC_INC = 32'd4.
- One sub-module, if_skid_buf: a one-entry 64-bit holding register with load/clear/valid.

Test Plan:
- Reset, 1-cycle memory, no stall → requests at 0x0,0x4,0x8; IF_instruction matches rdata in order; IF_incrementedPC=0x4,0x8,0xC.
- Stall for 3 cycles while a response arrives → outputs held unchanged; the word lands in skid; after release the held word is consumed, then the skid word appears; no request is issued during S_HOLD.
- Redirect to 0x0000_0400 while in S_WAIT (data arrives 2 cycles later) → stale word discarded, IF_valid=0, next request addr=0x400, IF_incrementedPC=0x404.
- Redirect in the same cycle as req&ready at 0x10 → response for 0x10 never reaches output; next request addr = redirect target.
- RESET_PC=32'hFFFF_FFFC → first IF_incrementedPC=0x0000_0000, next request addr=0x0 (wrap).
- i_reset asserted while in S_WAIT → all outputs reset values next cycle; a fetch restarts at RESET_PC after S_IDLE.
